// File: rtl/conv2d_stream.sv
// Streaming KxK valid-mode 2D convolution over a raster pixel stream; CONV2D_RELU_EN clamps results at zero.
// Latency: one cycle from the handshake of a window-completing pixel to out_valid.
// Backpressure: pix_ready drops while a result is held unconsumed, so no result is ever overwritten.
module conv2d_stream #(
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32,
    parameter int K      = 5,
    parameter int DATA_W = 16,
    localparam int ACC_W = 2*DATA_W + $clog2(K*K),
    localparam int CA_W  = $clog2(K*K)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    input  logic              coef_we,
    input  logic [CA_W-1:0]   coef_addr,
    input  logic [DATA_W-1:0] coef_data,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic [DATA_W-1:0] pix_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic              out_last
);

    localparam int CW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW   = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int NOUT = (IMG_H-K+1) * (IMG_W-K+1);
    localparam int OW   = $clog2(NOUT+1);
    localparam int PW   = 2*DATA_W;

    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_nxt;

    logic signed [DATA_W-1:0] coef    [K*K];
    logic signed [DATA_W-1:0] lbuf    [K-1][IMG_W];
    logic signed [DATA_W-1:0] win     [K][K];
    logic signed [DATA_W-1:0] win_nxt [K][K];

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [OW-1:0] out_idx;
    logic          all_in;
    logic          pix_hs, out_hs, win_full;
    logic signed [ACC_W-1:0] sum, res;

    function automatic logic signed [ACC_W-1:0] mac(input logic signed [DATA_W-1:0] a,
                                                    input logic signed [DATA_W-1:0] b);
        logic signed [PW-1:0] p;
        p = PW'(a) * PW'(b);
        return {{(ACC_W-PW){p[PW-1]}}, p};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (out_hs && out_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state == RUN);
        pix_ready = (state == RUN) && !all_in && (!out_valid || out_ready);
    end

    assign pix_hs   = pix_valid && pix_ready;
    assign out_hs   = out_valid && out_ready;
    assign win_full = (row >= RW'(K-1)) && (col >= CW'(K-1));

    // Window as it will look after absorbing the incoming pixel's column.
    always_comb begin
        for (int kr = 0; kr < K; kr++) begin
            for (int kc = 0; kc < K-1; kc++) begin
                win_nxt[kr][kc] = win[kr][kc+1];
            end
        end
        for (int kr = 0; kr < K-1; kr++) begin
            win_nxt[kr][K-1] = lbuf[kr][col];
        end
        win_nxt[K-1][K-1] = pix_data;
    end

    always_comb begin
        sum = '0;
        for (int kr = 0; kr < K; kr++) begin
            for (int kc = 0; kc < K; kc++) begin
                sum = sum + mac(win_nxt[kr][kc], coef[kr*K+kc]);
            end
        end
`ifdef CONV2D_RELU_EN
        res = sum[ACC_W-1] ? '0 : sum;
`else
        res = sum;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < K*K; i++) coef[i] <= '0;
            for (int kr = 0; kr < K-1; kr++)
                for (int c = 0; c < IMG_W; c++) lbuf[kr][c] <= '0;
            for (int kr = 0; kr < K; kr++)
                for (int kc = 0; kc < K; kc++) win[kr][kc] <= '0;
            col       <= '0;
            row       <= '0;
            all_in    <= 1'b0;
            out_idx   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= (state == RUN) && out_hs && out_last;

            if (state == IDLE) begin
                if (coef_we && (32'(coef_addr) < K*K)) coef[coef_addr] <= coef_data;
                if (start) begin
                    col     <= '0;
                    row     <= '0;
                    all_in  <= 1'b0;
                    out_idx <= '0;
                end
            end

            if (pix_hs) begin
                win <= win_nxt;
                // Line buffers shift up one row at this column; row K-2 takes the new pixel.
                for (int kr = 0; kr < K-2; kr++) lbuf[kr][col] <= lbuf[kr+1][col];
                lbuf[K-2][col] <= pix_data;
                if (col == CW'(IMG_W-1)) begin
                    col <= '0;
                    if (row == RW'(IMG_H-1)) begin
                        row    <= '0;
                        all_in <= 1'b1;
                    end else begin
                        row <= row + RW'(1);
                    end
                end else begin
                    col <= col + CW'(1);
                end
            end

            if (pix_hs && win_full) begin
                out_valid <= 1'b1;
                out_data  <= res;
                out_last  <= (out_idx == OW'(NOUT-1));
                out_idx   <= out_idx + OW'(1);
            end else if (out_hs) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_conv2d_stream.sv
// Self-checking bench for conv2d_stream: table-driven frames against a direct convolution model,
// plus hand-written reset and mid-frame abort sequences.
module tb_conv2d_stream;

    localparam int IMG_W  = 32;
    localparam int IMG_H  = 32;
    localparam int K      = 5;
    localparam int DATA_W = 16;
    localparam int ACC_W  = 2*DATA_W + $clog2(K*K);
    localparam int CA_W   = $clog2(K*K);
    localparam int NPIX   = IMG_W*IMG_H;
    localparam int OUT_W  = IMG_W-K+1;
    localparam int NOUT   = (IMG_H-K+1)*OUT_W;
`ifdef CONV2D_RELU_EN
    localparam longint NEG_FIRST = 0;
`else
    localparam longint NEG_FIRST = -25;
`endif

    logic              clk, rst, start, busy, done;
    logic              coef_we;
    logic [CA_W-1:0]   coef_addr;
    logic [DATA_W-1:0] coef_data;
    logic              pix_valid, pix_ready;
    logic [DATA_W-1:0] pix_data;
    logic              out_valid, out_ready, out_last;
    logic [ACC_W-1:0]  out_data;

    conv2d_stream #(.IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int     img  [NPIX];
    int     cf   [K*K];
    longint expv [NOUT];
    int     n_cmp  = 0;
    int     n_fail = 0;

    typedef struct {
        int     cmode;      // 0 all 1, 1 centre tap, 2 all -1, 3 random
        int     pmode;      // 0 all 1, 1 ramp r*32+c, 2 random
        int     mode;       // 0 free-flow, 1 random valid/ready, 2 output stall, 3 start/coef_we in RUN
        bit     reload;
        bit     has_first;
        longint first;
    } vec_t;

    vec_t tbl [7];

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void set_coefs(input int cmode);
        logic signed [DATA_W-1:0] v;
        for (int i = 0; i < K*K; i++) begin
            v = DATA_W'($urandom());
            case (cmode)
                0:       cf[i] = 1;
                1:       cf[i] = (i == 12) ? 1 : 0;
                2:       cf[i] = -1;
                default: cf[i] = int'(v);
            endcase
        end
    endfunction

    function automatic void set_pixels(input int pmode);
        logic signed [DATA_W-1:0] v;
        for (int i = 0; i < NPIX; i++) begin
            v = DATA_W'($urandom());
            case (pmode)
                0:       img[i] = 1;
                1:       img[i] = (i / IMG_W) * 32 + (i % IMG_W);
                default: img[i] = int'(v);
            endcase
        end
    endfunction

    // Direct valid-mode convolution, outputs in raster order.
    function automatic void build_model();
        longint s;
        for (int i = 0; i < IMG_H-K+1; i++) begin
            for (int j = 0; j < OUT_W; j++) begin
                s = 0;
                for (int kr = 0; kr < K; kr++)
                    for (int kc = 0; kc < K; kc++)
                        s += longint'(cf[kr*K+kc]) * longint'(img[(i+kr)*IMG_W + j+kc]);
`ifdef CONV2D_RELU_EN
                if (s < 0) s = 0;
`endif
                expv[i*OUT_W + j] = s;
            end
        end
    endfunction

    task automatic load_coefs();
        for (int a = 0; a < K*K; a++) begin
            @(posedge clk); #1;
            coef_we   = 1'b1;
            coef_addr = CA_W'(a);
            coef_data = DATA_W'(cf[a]);
        end
        @(posedge clk); #1;
        coef_we = 1'b0;
    endtask

    task automatic run_frame(input int mode, input bit has_first, input longint first);
        int pix_i = 0, out_i = 0, cyc = 0, stall_cnt = 0;
        bit exp_ov = 0, hold_chk = 0, fin = 0;
        logic [ACC_W-1:0] held = '0;
        longint first_got = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", busy, 1);
        while (!fin && cyc < 20000) begin
            coef_we   = 1'b0;
            start     = 1'b0;
            pix_valid = (pix_i < NPIX) && ((mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1);
            pix_data  = DATA_W'(img[(pix_i < NPIX) ? pix_i : 0]);
            out_ready = (mode == 1) ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (mode == 2 && out_i >= 300 && stall_cnt < 10) begin
                out_ready = 1'b0;
                stall_cnt++;
            end
            if (mode == 3 && pix_i == 200) begin
                start     = 1'b1;
                coef_we   = 1'b1;
                coef_addr = '0;
                coef_data = DATA_W'(7);
            end
            #1;
            if (exp_ov) check("latency_out_valid", out_valid, 1);
            if (hold_chk) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, held);
            end
            if (out_valid && !out_ready) check("pix_ready_stalled", pix_ready, 0);
            if (pix_i == NPIX) check("pix_ready_after_last", pix_ready, 0);
            check("no_early_done", done, 0);
            exp_ov = 0;
            if (pix_valid && pix_ready) begin
                if (pix_i / IMG_W >= K-1 && pix_i % IMG_W >= K-1) exp_ov = 1;
                pix_i++;
            end
            if (out_valid && out_ready) begin
                if (out_i >= NOUT) begin
                    check("extra_output", out_i, NOUT-1);
                end else begin
                    check("out_data", $signed(out_data), expv[out_i]);
                    check("out_last", out_last, out_i == NOUT-1);
                    if (out_i == 0) first_got = $signed(out_data);
                    if (out_i == NOUT-1) fin = 1;
                end
                out_i++;
            end
            hold_chk = out_valid && !out_ready;
            held     = out_data;
            @(posedge clk); #1;
            cyc++;
        end
        pix_valid = 1'b0;
        out_ready = 1'b1;
        coef_we   = 1'b0;
        start     = 1'b0;
        if (!fin) begin
            check("frame_timeout", out_i, NOUT);
        end else begin
            check("done_after_last", done, 1);
            check("busy_after_last", busy, 0);
            check("pix_ready_idle", pix_ready, 0);
        end
        check("output_count", out_i, NOUT);
        if (has_first) check("first_output", first_got, first);
        @(posedge clk); #1;
        check("done_one_cycle", done, 0);
    endtask

    initial begin
        int cnt, cyc;
        rst = 1'b1; start = 1'b0; coef_we = 1'b0; coef_addr = '0; coef_data = '0;
        pix_valid = 1'b0; pix_data = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pix_ready", pix_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_data", out_data, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        tbl[0] = '{cmode: 0, pmode: 0, mode: 0, reload: 1, has_first: 1, first: 25};
        tbl[1] = '{cmode: 1, pmode: 1, mode: 1, reload: 1, has_first: 1, first: 66};
        tbl[2] = '{cmode: 0, pmode: 0, mode: 2, reload: 1, has_first: 1, first: 25};
        tbl[3] = '{cmode: 2, pmode: 0, mode: 1, reload: 1, has_first: 1, first: NEG_FIRST};
        tbl[4] = '{cmode: 3, pmode: 2, mode: 1, reload: 1, has_first: 0, first: 0};
        tbl[5] = '{cmode: 0, pmode: 0, mode: 3, reload: 1, has_first: 1, first: 25};
        tbl[6] = '{cmode: 0, pmode: 0, mode: 0, reload: 0, has_first: 1, first: 25};

        for (int t = 0; t < 7; t++) begin
            set_pixels(tbl[t].pmode);
            if (tbl[t].reload) begin
                set_coefs(tbl[t].cmode);
                load_coefs();
            end
            build_model();
            run_frame(tbl[t].mode, tbl[t].has_first, tbl[t].first);
        end

        // Abort a frame after 100 pixels with a synchronous reset.
        set_coefs(0);
        load_coefs();
        set_pixels(2);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cnt = 0;
        cyc = 0;
        while (cnt < 100 && cyc < 1000) begin
            pix_valid = 1'b1;
            pix_data  = DATA_W'(img[cnt]);
            out_ready = 1'b1;
            #1;
            if (pix_ready) cnt++;
            @(posedge clk); #1;
            cyc++;
        end
        check("partial_feed", cnt, 100);
        rst       = 1'b1;
        pix_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_out_data", out_data, 0);
        check("abort_out_last", out_last, 0);
        check("abort_pix_ready", pix_ready, 0);
        for (int i = 0; i < 5; i++) begin
            check("abort_no_done", done, 0);
            @(posedge clk); #1;
        end

        // Coefficients were cleared by the reset: a frame without reloading gives all zeros.
        for (int i = 0; i < K*K; i++) cf[i] = 0;
        build_model();
        run_frame(1, 1, 0);

        set_coefs(0);
        set_pixels(0);
        load_coefs();
        build_model();
        run_frame(0, 1, 25);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/conv2d_stream.md
CONV2D_STREAM -- requirements
Module: conv2d_stream

Interface
REQ-001 The block SHALL have parameter IMG_W, default 32, meaning image width in pixels.
REQ-002 The block SHALL have parameter IMG_H, default 32, meaning image height in pixels.
REQ-003 The block SHALL have parameter K, default 5, meaning square kernel side.
REQ-004 The block SHALL have parameter DATA_W, default 16, meaning signed pixel/coefficient width.
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; all logic rising-edge.
REQ-006 The block SHALL have port rst, input, 1 bit, reset: synchronous, active-high.
REQ-007 The block SHALL have port start, input, 1 bit, frame start pulse.
REQ-008 The block SHALL have ports busy and done, outputs, 1 bit each: frame in progress; one-cycle frame-complete pulse.
REQ-009 The block SHALL have ports coef_we (input, 1 bit), coef_addr (input, clog2(K*K) bits) and coef_data (input, DATA_W bits): coefficient write; addr = kr*K+kc.
REQ-010 The block SHALL have ports pix_valid (input, 1 bit), pix_ready (output, 1 bit) and pix_data (input, DATA_W bits): raster-order pixel stream.
REQ-011 The block SHALL have ports out_valid (output, 1 bit), out_ready (input, 1 bit), out_data (output, ACC_W bits) and out_last (output, 1 bit), where ACC_W = 2*DATA_W+clog2(K*K).

Function
REQ-012 The state machine SHALL have states IDLE and RUN: IDLE->RUN on start; RUN->IDLE the cycle after the final output handshake, with done=1 for that one cycle.
REQ-013 busy SHALL be 1 exactly in RUN; start in RUN SHALL be ignored.
REQ-014 coef_we SHALL write coef[coef_addr] only in IDLE; writes in RUN SHALL be ignored and coefficients SHALL persist across frames.
REQ-015 pix_ready SHALL equal RUN && (!out_valid || out_ready); pixels SHALL be accepted only on pix_valid && pix_ready.
REQ-016 Column and row counters SHALL advance on each accepted pixel, column wrapping at IMG_W-1 to 0 with row increment.
REQ-017 K-1 line buffers of IMG_W entries plus a KxK window register SHALL hold the latest K rows; no padding (valid convolution).
REQ-018 When the accepted pixel is at (r,c) with r>=K-1 and c>=K-1, output (r-K+1, c-K+1) SHALL be sum over kr,kc of coef[kr*K+kc]*pixel(r-K+1+kr, c-K+1+kc).
REQ-019 The result SHALL appear with out_valid=1 on the cycle after that pixel's handshake (latency 1).
REQ-020 Arithmetic SHALL be signed two's complement at full ACC_W precision, with no truncation or saturation.
REQ-021 out_data and out_last SHALL hold stable while out_valid && !out_ready; no output SHALL be lost or duplicated.
REQ-022 out_last SHALL be 1 only on output index (IMG_H-K+1)*(IMG_W-K+1)-1.
REQ-023 Accepted pixels completing no window (r<K-1 or c<K-1) SHALL produce no output.
REQ-024 pix_ready SHALL be 0 in IDLE, and after the last pixel (IMG_W*IMG_H) is accepted until the frame returns to IDLE.

Reset
REQ-025 rst SHALL force IDLE with busy, done, pix_ready, out_valid and out_last at 0, out_data, counters, line buffers and window at 0, and all coefficients at 0.
REQ-026 rst asserted mid-frame SHALL abort the frame with no done pulse; the next start SHALL begin a clean frame.

Configuration
REQ-027 With CONV2D_RELU_EN defined, out_data SHALL be max(sum,0); without it, out_data SHALL be the raw signed sum.

Verification
REQ-028 Coefs all 1, pixels all 1 -> 784 outputs each 25, out_last on the 784th, done one cycle later, busy then 0.
REQ-029 Only coef[12]=1, pixel(r,c)=r*32+c -> output(i,j)=(i+2)*32+(j+2), in raster order.
REQ-030 out_ready held 0 for 10 cycles mid-frame -> out_data stable, pix_ready 0; resume -> all 784 outputs correct, none missing.
REQ-031 Coefs all -1, pixels all 1 -> every output -25 without CONV2D_RELU_EN, 0 with it.
REQ-032 rst after 100 pixels -> next cycle all outputs 0, busy 0, no done; reload coefs and rerun frame -> REQ-028 result.
REQ-033 start and coef_we (addr 0, data 7) asserted during RUN -> no restart, outputs unchanged, coef[0] unchanged in the next frame.
